// File: rtl/clm_mul_digit_serial.sv
// Digit-serial GF(2)[x] multiplier: out = (a * b) mod M, M = x^N + mod_i, N = 8+D.
// Optional output refresh by rnd * P_FIELD when CLM_MUL_REFRESH_EN is defined.
module clm_mul_digit_serial #(
    parameter int         D       = 8,
    parameter int         DIGIT   = 1,
    parameter logic [8:0] P_FIELD = 9'h11B
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           drdy_i,
    input  logic [8+D-1:0] a_i,
    input  logic [8+D-1:0] b_i,
    input  logic [8+D-1:0] mod_i,
    input  logic [D-1:0]   rnd_i,
    output logic           busy_o,
    output logic           drdy_o,
    output logic [8+D-1:0] out
);

    localparam int N     = 8 + D;
    localparam int STEPS = N / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (N % DIGIT != 0) begin : g_digit_check
            $error("clm_mul_digit_serial: N must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [N-1:0]     a_reg;
    logic [N-1:0]     b_reg;
    logic [N-1:0]     mod_reg;
    logic [N-1:0]     acc_reg;
    logic [N-1:0]     out_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             drdy_reg;

    logic [N-1:0]     acc_next;
    logic [N-1:0]     refresh;

    // Horner step per consumed bit; b_reg is shifted so its MSBs are always the current digit.
    always_comb begin
        acc_next = acc_reg;
        for (int j = 0; j < DIGIT; j++) begin
            acc_next = {acc_next[N-2:0], 1'b0}
                     ^ (acc_next[N-1] ? mod_reg : '0)
                     ^ (b_reg[N-1-j] ? a_reg : '0);
        end
    end

`ifdef CLM_MUL_REFRESH_EN
    logic [D-1:0]          rnd_reg;
    logic [D-1:0][N-1:0]   pp;

    // rnd * P has degree <= N-1, so the partial products never need reduction.
    for (genvar gi = 0; gi < D; gi++) begin : g_pp
        assign pp[gi] = rnd_reg[gi] ? (N'(P_FIELD) << gi) : '0;
    end

    always_comb begin
        refresh = '0;
        for (int i = 0; i < D; i++) begin
            refresh = refresh ^ pp[i];
        end
    end
`else
    logic unused_rnd;
    assign unused_rnd = ^{rnd_i, P_FIELD};
    assign refresh    = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            mod_reg   <= '0;
            acc_reg   <= '0;
            out_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            drdy_reg  <= 1'b0;
`ifdef CLM_MUL_REFRESH_EN
            rnd_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    drdy_reg <= 1'b0;
                    if (drdy_i) begin
                        a_reg     <= a_i;
                        b_reg     <= b_i;
                        mod_reg   <= mod_i;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= S_RUN;
`ifdef CLM_MUL_REFRESH_EN
                        rnd_reg   <= rnd_i;
`endif
                    end
                end
                S_RUN: begin
                    acc_reg <= acc_next;
                    b_reg   <= b_reg << DIGIT;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(STEPS - 1)) begin
                        out_reg   <= acc_next ^ refresh;
                        drdy_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    drdy_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    drdy_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_reg;
    assign drdy_o = drdy_reg;
    assign out    = out_reg;

endmodule
